// File: rtl/bus_init_seq_pkg.sv
// Shared types for the host-driven peripheral bus initiator.
package bus_init_seq_pkg;

    localparam int BUS_ADDR_W = 24;
    localparam int BUS_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        HOLD,
        RESP
    } state_e;

    typedef struct packed {
        logic                  write;
        logic [BUS_ADDR_W-1:0] address;
        logic [BUS_DATA_W-1:0] data;
    } cmd_t;

endpackage

// File: rtl/bus_init_seq_cmd_fifo.sv
// Small synchronous command FIFO; caller never pushes when full.
module bus_init_seq_cmd_fifo
    import bus_init_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  cmd_t din_i,
    input  logic pop_i,
    output cmd_t dout_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [AW:0]   cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, push_i}
                           - {{AW{1'b0}}, pop_i};
        end
    end

    // Storage needs no reset; the count alone defines validity.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/bus_init_seq.sv
// Replays queued host register reads/writes as three-tick bus cycles.
module bus_init_seq
    import bus_init_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_ce,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [BUS_ADDR_W-1:0] cmd_address,
    input  logic [BUS_DATA_W-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [BUS_DATA_W-1:0] rsp_data,
    output logic                  bus_req,
    input  logic                  bus_grant,
    output logic                  bus_write,
    output logic [BUS_ADDR_W-1:0] bus_address_out,
    output logic [BUS_DATA_W-1:0] bus_data_out,
    input  logic [BUS_DATA_W-1:0] bus_data_in,
    output logic                  busy
);

    cmd_t head;
    cmd_t push_cmd;
    logic full;
    logic empty;
    logic push;
    logic pop;

    state_e                state_q;
    logic                  txn_write_q;
    logic                  bus_write_q;
    logic [BUS_ADDR_W-1:0] addr_q;
    logic [BUS_DATA_W-1:0] data_q;
    logic                  rsp_valid_q;
    logic                  rsp_write_q;
    logic [BUS_DATA_W-1:0] rsp_data_q;

    assign push_cmd = '{write: cmd_write,
                        address: cmd_address,
                        data: cmd_data};
    assign push = cmd_valid && !full;
    assign pop  = clk_ce && (state_q == IDLE)
               && !empty && bus_grant;

    bus_init_seq_cmd_fifo #(
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (push_cmd),
        .pop_i   (pop),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            txn_write_q <= 1'b0;
            bus_write_q <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            if (clk_ce) begin
                unique case (state_q)
                    IDLE: begin
                        if (!empty && bus_grant) begin
                            addr_q      <= head.address;
                            data_q      <= head.data;
                            bus_write_q <= head.write;
                            txn_write_q <= head.write;
                            state_q     <= ADDR;
                        end
                    end
                    ADDR: begin
                        bus_write_q <= 1'b0;
                        rsp_data_q  <= txn_write_q ? '0 : bus_data_in;
                        state_q     <= HOLD;
                    end
                    HOLD: begin
                        addr_q      <= '0;
                        data_q      <= '0;
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= txn_write_q;
                        state_q     <= RESP;
                    end
                    RESP: ;
                endcase
            end
            // The response handshake runs at core rate, not tick rate.
            if (state_q == RESP && rsp_valid_q && rsp_ready) begin
                rsp_valid_q <= 1'b0;
                state_q     <= IDLE;
            end
        end
    end

    assign cmd_ready       = !full;
    assign bus_req         = ((state_q == IDLE) && !empty)
                          || (state_q == ADDR)
                          || (state_q == HOLD);
    assign busy            = !empty || (state_q != IDLE);
    assign bus_write       = bus_write_q;
    assign bus_address_out = addr_q;
    assign bus_data_out    = data_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_write       = rsp_write_q;
    assign rsp_data        = rsp_data_q;

endmodule

// File: tb/tb_bus_init_seq.sv
// Randomized bench for bus_init_seq with a sequential register model.
module tb_bus_init_seq;

    logic        clk;
    logic        reset;
    logic        clk_ce;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [23:0] cmd_address;
    logic [7:0]  cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [7:0]  rsp_data;
    logic        bus_req;
    logic        bus_grant;
    logic        bus_write;
    logic [23:0] bus_address_out;
    logic [7:0]  bus_data_out;
    logic [7:0]  bus_data_in;
    logic        busy;

    bus_init_seq #(.CMD_DEPTH(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .clk_ce          (clk_ce),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_write       (cmd_write),
        .cmd_address     (cmd_address),
        .cmd_data        (cmd_data),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_write       (rsp_write),
        .rsp_data        (rsp_data),
        .bus_req         (bus_req),
        .bus_grant       (bus_grant),
        .bus_write       (bus_write),
        .bus_address_out (bus_address_out),
        .bus_data_out    (bus_data_out),
        .bus_data_in     (bus_data_in),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h",
                     tag, got, exp);
        end
    endtask

    // Peripheral register block at 0x2070..0x207F.
    logic [7:0] periph [16];
    function automatic logic in_rng(input logic [23:0] a);
        return a[23:4] == 20'h00207;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) periph[i] <= 8'h00;
        end else if (clk_ce && bus_write && in_rng(bus_address_out)) begin
            periph[bus_address_out[3:0]] <= bus_data_out;
        end
    end
    assign bus_data_in = in_rng(bus_address_out)
                       ? periph[bus_address_out[3:0]] : 8'h00;

    // Reference: commands take effect in push order, one at a time.
    typedef struct packed {
        logic       w;
        logic [7:0] d;
    } exp_t;
    exp_t       exp_q [$];
    logic [7:0] model [16];
    int         wticks;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            wticks = 0;
            for (int i = 0; i < 16; i++) model[i] = 8'h00;
        end else begin
            if (clk_ce && bus_write) wticks++;
            if (cmd_valid && cmd_ready) begin
                e.w = cmd_write;
                e.d = 8'h00;
                if (in_rng(cmd_address)) begin
                    if (cmd_write) model[cmd_address[3:0]] = cmd_data;
                    else e.d = model[cmd_address[3:0]];
                end
                exp_q.push_back(e);
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_write", rsp_write, e.w);
                    check("rsp_data", rsp_data, e.d);
                    check("wr_ticks", wticks, e.w ? 1 : 0);
                end
                wticks = 0;
            end
        end
    end

    int cyc     = 0;
    int ce_mode = 0;
    bit rnd_rdy = 0;
    bit rnd_gnt = 0;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        case (ce_mode)
            0:       clk_ce = 1'b1;
            1:       clk_ce = (cyc % 4 == 0);
            default: clk_ce = 1'($urandom_range(0, 1));
        endcase
        if (rnd_rdy) rsp_ready = 1'($urandom_range(0, 1));
        if (rnd_gnt) bus_grant = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input logic w, input logic [23:0] a,
                        input logic [7:0] d);
        int  n    = 0;
        bit  done = 0;
        cmd_valid   = 1'b1;
        cmd_write   = w;
        cmd_address = a;
        cmd_data    = d;
        while (!done && n < 400) begin
            done = cmd_ready;
            step();
            n++;
        end
        cmd_valid = 1'b0;
        if (!done) check("push_timeout", 0, 1);
    endtask

    task automatic push_rand();
        logic [23:0] a;
        if ($urandom_range(0, 7) == 0) a = 24'($urandom_range(0, 255));
        else a = 24'h2070 + 24'($urandom_range(0, 15));
        push(1'($urandom_range(0, 1)), a, 8'($urandom));
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 3000) begin
            step();
            n++;
        end
        check("drain_timeout", (n < 3000) ? 1 : 0, 1);
    endtask

    task automatic wait_rsp();
        int n = 0;
        while (!rsp_valid && n < 200) begin
            step();
            n++;
        end
        check("rsp_timeout", rsp_valid, 1);
    endtask

    initial begin
        int wc, ac, dc, rq;
        reset = 1'b1; clk_ce = 1'b1; cmd_valid = 1'b0;
        cmd_write = 1'b0; cmd_address = '0; cmd_data = '0;
        rsp_ready = 1'b1; bus_grant = 1'b1;
        step(); step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_write", rsp_write, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_write", bus_write, 0);
        check("rst_addr", bus_address_out, 0);
        check("rst_data", bus_data_out, 0);
        check("rst_busy", busy, 0);
        reset = 1'b0;
        step();

        // Full-rate write: strobe one tick, address/data two.
        push(1'b1, 24'h2071, 8'h03);
        wc = 0; ac = 0; dc = 0;
        for (int i = 0; i < 8; i++) begin
            wc += int'(bus_write);
            ac += int'(bus_address_out == 24'h2071);
            dc += int'(bus_data_out == 8'h03);
            step();
        end
        check("wr_strobe_cycles", wc, 1);
        check("wr_addr_cycles", ac, 2);
        check("wr_data_cycles", dc, 2);
        check("periph_vol", periph[1], 8'h03);
        drain();
        push(1'b0, 24'h2071, 8'h00);
        drain();

        // Read-after-write with a stalled response.
        rsp_ready = 1'b0;
        push(1'b1, 24'h2070, 8'h05);
        wait_rsp();
        for (int i = 0; i < 5; i++) step();
        check("rsp_hold_wr", rsp_valid, 1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        push(1'b0, 24'h2070, 8'h00);
        wait_rsp();
        check("rd_data_2070", rsp_data, 8'h05);
        for (int i = 0; i < 5; i++) step();
        check("rsp_hold_rd", rsp_valid, 1);
        rsp_ready = 1'b1;
        drain();

        // Five commands with no grant: queue fills, no bus activity.
        bus_grant = 1'b0;
        for (int i = 0; i < 4; i++)
            push(1'b1, 24'h2074 + 24'(i), 8'h10 + 8'(i));
        check("full_ready_low", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_write = 1'b0;
        cmd_address = 24'h2076; cmd_data = 8'h00;
        wc = 0;
        for (int i = 0; i < 6; i++) begin
            wc += int'(bus_write);
            step();
        end
        cmd_valid = 1'b0;
        check("nogrant_ready", cmd_ready, 0);
        check("nogrant_req", bus_req, 1);
        check("nogrant_strobes", wc, 0);
        bus_grant = 1'b1;
        push(1'b0, 24'h2076, 8'h00);
        drain();

        // Tick every fourth cycle.
        ce_mode = 1;
        for (int i = 0; i < 12; i++) push_rand();
        drain();

        // Second command must wait for the first response.
        ce_mode = 0;
        rsp_ready = 1'b0;
        push(1'b1, 24'h207A, 8'h5A);
        push(1'b0, 24'h207A, 8'h00);
        wait_rsp();
        rq = 0;
        for (int i = 0; i < 10; i++) begin
            rq += int'(bus_req) + int'(bus_address_out != 0);
            step();
        end
        check("stall_no_start", rq, 0);
        check("stall_busy", busy, 1);
        rsp_ready = 1'b1;
        drain();

        // Fully random phase.
        ce_mode = 2; rnd_rdy = 1; rnd_gnt = 1;
        for (int i = 0; i < 60; i++) push_rand();
        drain();
        ce_mode = 0; rnd_rdy = 0; rnd_gnt = 0;
        rsp_ready = 1'b1; bus_grant = 1'b1;
        step();

        // Reset during the address phase of a write.
        push(1'b1, 24'h2072, 8'hAA);
        push(1'b0, 24'h2072, 8'h00);
        check("pre_rst_strobe", bus_write, 1);
        reset = 1'b1;
        step();
        check("mid_rst_strobe", bus_write, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", cmd_ready, 1);
        check("mid_rst_req", bus_req, 0);
        check("mid_rst_addr", bus_address_out, 0);
        check("mid_rst_rsp", rsp_valid, 0);
        reset = 1'b0;
        rq = 0;
        for (int i = 0; i < 8; i++) begin
            rq += int'(rsp_valid) + int'(busy) + int'(bus_write);
            step();
        end
        check("post_rst_quiet", rq, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
